// File: rtl/cic_pkg.sv
// Shared constants, state encoding and helpers for the CIC decimation sequencer.
package cic_pkg;

  // Defaults matching the FM receive chain's CIC filter
  localparam int CIC_R_MAX     = 16;
  localparam int CIC_R_DEFAULT = 5;
  localparam int CIC_ORDER     = 3;
  localparam int CIC_FLUSH_LEN = 2;

  // Sequencer phases: clear the filter, wait for the combs to settle, then run
  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Ceiling log2 with a fixed loop bound so it stays elaboration-friendly
  function automatic int cic_clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        n = i + 1;
      end
    end
    return n;
  endfunction

  // Bit growth of the driven CIC: input width plus ORDER * ceil(log2(R))
  function automatic int cic_out_width(input int width, input int r, input int order);
    return width + order * cic_clog2(r);
  endfunction

endpackage

// File: rtl/cic_phase_counter.sv
// Modulo-N phase counter: counts input strobes and flags the last phase of each decimation period.
module cic_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_mod,
  output logic         o_tc
);

  logic [W-1:0] r_phase;

  // Terminal count is the phase that precedes the wrap back to zero
  assign o_tc = (r_phase == (i_mod - W'(1)));

  // Clear wins over enable so a ratio reload always restarts the period at phase 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      if (o_tc) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + W'(1);
      end
    end
  end

endmodule

// File: rtl/cic_decim_sequencer.sv
// CIC decimation sequencer: drives integrator enable, decimation strobe and output
// qualification, with run-time ratio reload, filter flush and comb settling mask.
module cic_decim_sequencer
  import cic_pkg::*;
#(
  parameter int R_MAX     = CIC_R_MAX,
  parameter int R_DEFAULT = CIC_R_DEFAULT,
  parameter int ORDER     = CIC_ORDER,
  parameter int FLUSH_LEN = CIC_FLUSH_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en_src,
  input  logic [$clog2(R_MAX+1)-1:0] cfg_r,
  input  logic                       cfg_load,
  output logic                       cfg_err,
  output logic                       filter_clr,
  output logic                       en_in,
  output logic                       en_out,
  output logic                       valid,
  output logic                       busy,
  output logic [$clog2(R_MAX+1)-1:0] r_active
);

  localparam int RW = $clog2(R_MAX + 1);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int SW = (ORDER > 1) ? $clog2(ORDER) : 1;

  state_t        r_state;
  state_t        w_stateNext;
  logic [FW-1:0] r_flushCnt;
  logic [FW-1:0] w_flushCntNext;
  logic [SW-1:0] r_settleCnt;
  logic [SW-1:0] w_settleCntNext;

  logic w_loadOk;
  logic w_loadBad;
  logic w_running;
  logic w_tc;
  logic w_strobeIn;
  logic w_strobeOut;
  logic w_phaseClr;

  // A load is honoured only for ratios 1..R_MAX; anything else just raises cfg_err
  assign w_loadOk  = cfg_load && (cfg_r != '0) && (cfg_r <= RW'(R_MAX));
  assign w_loadBad = cfg_load && !w_loadOk;

  // Strobes pass only outside FLUSH, and a source strobe coinciding with a reload is dropped
  assign w_running   = (r_state != FLUSH);
  assign w_strobeIn  = en_src && w_running && !w_loadOk;
  assign w_strobeOut = w_strobeIn && w_tc;
  assign w_phaseClr  = (r_state == FLUSH) || w_loadOk;

  cic_phase_counter #(
    .W(RW)
  ) u_phaseCounter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_phaseClr),
    .i_en  (w_strobeIn),
    .i_mod (r_active),
    .o_tc  (w_tc)
  );

  // Next-state logic: reload forces a fresh flush, FLUSH times out, SETTLE counts decimated strobes
  always_comb begin
    w_stateNext     = r_state;
    w_flushCntNext  = r_flushCnt;
    w_settleCntNext = r_settleCnt;
    if (w_loadOk) begin
      w_stateNext     = FLUSH;
      w_flushCntNext  = '0;
      w_settleCntNext = '0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flushCnt == FW'(FLUSH_LEN - 1)) begin
            w_stateNext    = SETTLE;
            w_flushCntNext = '0;
          end else begin
            w_flushCntNext = r_flushCnt + FW'(1);
          end
          w_settleCntNext = '0;
        end
        SETTLE: begin
          if (w_strobeOut) begin
            if (r_settleCnt == SW'(ORDER - 1)) begin
              w_stateNext     = RUN;
              w_settleCntNext = '0;
            end else begin
              w_settleCntNext = r_settleCnt + SW'(1);
            end
          end
        end
        RUN: begin
          w_stateNext = RUN;
        end
        default: begin
          w_stateNext = FLUSH;
        end
      endcase
    end
  end

  // State, counters and all outputs are registered; clear/busy follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FLUSH;
      r_flushCnt  <= '0;
      r_settleCnt <= '0;
      r_active    <= RW'(R_DEFAULT);
      filter_clr  <= 1'b1;
      busy        <= 1'b1;
      en_in       <= 1'b0;
      en_out      <= 1'b0;
      valid       <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_flushCnt  <= w_flushCntNext;
      r_settleCnt <= w_settleCntNext;
      if (w_loadOk) begin
        r_active <= cfg_r;
      end
      filter_clr <= (w_stateNext == FLUSH);
      busy       <= (w_stateNext != RUN);
      en_in      <= w_strobeIn;
      en_out     <= w_strobeOut;
      valid      <= w_strobeOut && (r_state == RUN);
      cfg_err    <= w_loadBad;
    end
  end

endmodule
